// File: rtl/rr_replay_pkt_unpacker_if.sv
// Packet-in / beat-out bundle for the replay packet unpacker.
// The master side feeds packets and consumes beats; the slave side is the unpacker.
interface rr_replay_pkt_unpacker_if #(
    parameter int unsigned WIDTH            = 151,
    parameter int unsigned OFFSET_WIDTH     = 8,
    parameter int unsigned IDX_WIDTH        = 4,
    parameter int unsigned CH_MAX_WIDTH     = 8,
    parameter int unsigned LOGE_CHANNEL_CNT = 25
) ();
    logic                        in_valid;
    logic                        in_ready;
    logic [WIDTH-1:0]            in_pkt;
    logic [OFFSET_WIDTH-1:0]     in_width;
    logic                        out_valid;
    logic                        out_ready;
    logic [IDX_WIDTH-1:0]        out_idx;
    logic [CH_MAX_WIDTH-1:0]     out_data;
    logic                        out_empty;
    logic                        out_last;
    logic [LOGE_CHANNEL_CNT-1:0] out_loge;

    modport master (
        output in_valid, in_pkt, in_width, out_ready,
        input  in_ready, out_valid, out_idx, out_data, out_empty, out_last, out_loge
    );

    modport slave (
        input  in_valid, in_pkt, in_width, out_ready,
        output in_ready, out_valid, out_idx, out_data, out_empty, out_last, out_loge
    );
endinterface

// File: rtl/rr_replay_pkt_unpacker.sv
// Splits packed replay packets (logb bitmap, loge bitmap, LSB-first payloads) into
// one beat per logged logb channel, in ascending shuffled-channel index.
module rr_replay_pkt_unpacker #(
    parameter int unsigned LOGB_CHANNEL_CNT      = 14,
    parameter int unsigned LOGE_CHANNEL_CNT      = 25,
    parameter int unsigned RR_CHANNEL_WIDTH_BITS = 8,
    parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] SHUFFLED_CHANNEL_WIDTHS =
        {LOGB_CHANNEL_CNT{RR_CHANNEL_WIDTH_BITS'(8)}}
) (
    input  logic                          clk,
    input  logic                          rst,
    rr_replay_pkt_unpacker_if.slave       bus,
    output logic [31:0]                   pkt_cnt,
    output logic                          len_err
);

    function automatic int unsigned sum_widths();
        int unsigned s = 0;
        for (int i = 0; i < int'(LOGB_CHANNEL_CNT); i++) begin
            s += 32'(SHUFFLED_CHANNEL_WIDTHS[i]);
        end
        return s;
    endfunction

    function automatic int unsigned max_width();
        int unsigned m = 1;
        for (int i = 0; i < int'(LOGB_CHANNEL_CNT); i++) begin
            if (32'(SHUFFLED_CHANNEL_WIDTHS[i]) > m) m = 32'(SHUFFLED_CHANNEL_WIDTHS[i]);
        end
        return m;
    endfunction

    localparam int unsigned HDR          = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT;
    localparam int unsigned WIDTH        = HDR + sum_widths();
    localparam int unsigned OFFSET_WIDTH = $clog2(WIDTH + 1);
    localparam int unsigned CH_MAX_WIDTH = max_width();
    localparam int unsigned IDX_WIDTH    = (LOGB_CHANNEL_CNT > 1) ? $clog2(LOGB_CHANNEL_CNT) : 1;

    typedef enum logic [0:0] {StIdle = 1'b0, StEmit = 1'b1} state_e;

    state_e                        state_q, state_d;
    logic [WIDTH-1:0]              pkt_q, pkt_d;
    logic [LOGB_CHANNEL_CNT-1:0]   remaining_q, remaining_d;
    logic [OFFSET_WIDTH-1:0]       offset_q, offset_d;
    logic [LOGE_CHANNEL_CNT-1:0]   loge_q, loge_d;
    logic [31:0]                   pkt_cnt_q, pkt_cnt_d;
    logic                          len_err_q, len_err_d;

    logic [IDX_WIDTH-1:0]             cur_idx;
    logic [RR_CHANNEL_WIDTH_BITS-1:0] cur_width;
    logic [CH_MAX_WIDTH-1:0]          raw_data;
    logic [CH_MAX_WIDTH-1:0]          cur_data;
    logic [LOGB_CHANNEL_CNT-1:0]      remaining_next;
    logic [OFFSET_WIDTH-1:0]          in_len;
    logic                             emit;
    logic                             is_last;
    logic                             in_ready;
    logic                             accept;
    logic                             beat_hs;

    // Lowest set bit of the remaining bitmap selects the channel of the current beat.
    always_comb begin
        cur_idx   = '0;
        cur_width = '0;
        for (int i = int'(LOGB_CHANNEL_CNT) - 1; i >= 0; i--) begin
            if (remaining_q[i]) begin
                cur_idx   = IDX_WIDTH'(i);
                cur_width = SHUFFLED_CHANNEL_WIDTHS[i];
            end
        end
    end

    assign remaining_next = remaining_q & (remaining_q - LOGB_CHANNEL_CNT'(1));
    // At most one bit left; an all-zero bitmap is a single empty, last beat.
    assign is_last        = (remaining_next == '0);
    assign raw_data       = CH_MAX_WIDTH'(pkt_q >> offset_q);

    always_comb begin
        cur_data = '0;
        for (int b = 0; b < int'(CH_MAX_WIDTH); b++) begin
            cur_data[b] = raw_data[b] & (b < int'(cur_width));
        end
    end

    // Minimum legal length of the packet being offered.
    always_comb begin
        in_len = OFFSET_WIDTH'(HDR);
        for (int i = 0; i < int'(LOGB_CHANNEL_CNT); i++) begin
            if (bus.in_pkt[i]) in_len = in_len + OFFSET_WIDTH'(SHUFFLED_CHANNEL_WIDTHS[i]);
        end
    end

    assign emit     = (state_q == StEmit);
    assign beat_hs  = emit & bus.out_ready;
    assign in_ready = !emit | (is_last & bus.out_ready);
    assign accept   = bus.in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        pkt_d       = pkt_q;
        remaining_d = remaining_q;
        offset_d    = offset_q;
        loge_d      = loge_q;
        pkt_cnt_d   = pkt_cnt_q;
        len_err_d   = len_err_q;

        if (beat_hs) begin
            remaining_d = remaining_next;
            if (is_last) begin
                pkt_cnt_d = pkt_cnt_q + 32'd1;
                state_d   = StIdle;
            end else begin
                offset_d = offset_q + OFFSET_WIDTH'(cur_width);
            end
        end

        // A packet accepted on the last beat overrides the return to idle.
        if (accept) begin
            state_d     = StEmit;
            pkt_d       = bus.in_pkt;
            remaining_d = bus.in_pkt[LOGB_CHANNEL_CNT-1:0];
            offset_d    = OFFSET_WIDTH'(HDR);
            loge_d      = bus.in_pkt[LOGB_CHANNEL_CNT +: LOGE_CHANNEL_CNT];
            if (bus.in_width < in_len) len_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            pkt_q       <= '0;
            remaining_q <= '0;
            offset_q    <= '0;
            loge_q      <= '0;
            pkt_cnt_q   <= '0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pkt_q       <= pkt_d;
            remaining_q <= remaining_d;
            offset_q    <= offset_d;
            loge_q      <= loge_d;
            pkt_cnt_q   <= pkt_cnt_d;
            len_err_q   <= len_err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = emit;
    assign bus.out_idx   = emit ? cur_idx : '0;
    assign bus.out_data  = emit ? cur_data : '0;
    assign bus.out_empty = emit & (remaining_q == '0);
    assign bus.out_last  = emit & is_last;
    assign bus.out_loge  = loge_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign len_err       = len_err_q;

endmodule

// File: tb/tb_rr_replay_pkt_unpacker.sv
// Directed and randomized checks of the replay packet unpacker against a beat-list model.
module tb_rr_replay_pkt_unpacker;
    localparam int unsigned LOGB  = 3;
    localparam int unsigned LOGE  = 2;
    localparam int unsigned WIDTH = 33;
    localparam int unsigned OW    = 6;
    localparam int unsigned IW    = 2;
    localparam int unsigned CW    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pkt_cnt;
    logic        len_err;

    always #5 clk = ~clk;

    rr_replay_pkt_unpacker_if #(
        .WIDTH(WIDTH), .OFFSET_WIDTH(OW), .IDX_WIDTH(IW), .CH_MAX_WIDTH(CW),
        .LOGE_CHANNEL_CNT(LOGE)
    ) bus ();

    rr_replay_pkt_unpacker #(
        .LOGB_CHANNEL_CNT(LOGB),
        .LOGE_CHANNEL_CNT(LOGE),
        .RR_CHANNEL_WIDTH_BITS(8),
        .SHUFFLED_CHANNEL_WIDTHS({8'd4, 8'd16, 8'd8})
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .pkt_cnt(pkt_cnt),
        .len_err(len_err)
    );

    typedef struct {
        logic [LOGB-1:0]         logb;
        logic [LOGE-1:0]         loge;
        logic [LOGB-1:0][CW-1:0] pay;
        int unsigned             width;
        int unsigned             len;
        logic [WIDTH-1:0]        pkt;
    } tx_t;

    typedef struct {
        int unsigned     idx;
        logic [CW-1:0]   data;
        bit              empty;
        bit              last;
        logic [LOGE-1:0] loge;
    } beat_t;

    int unsigned ch_w [LOGB] = '{8, 16, 4};

    tx_t   tx_q [$];
    beat_t exp_q [$];
    int    checks = 0;
    int    failures = 0;
    int    model_cnt = 0;
    bit    model_err = 0;
    int    stall_cnt = 0;
    bit    rand_mode = 0;
    int    last_cycles = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic tx_t make_pkt(input logic [LOGB-1:0] logb, input logic [LOGE-1:0] loge,
                                     input logic [LOGB-1:0][CW-1:0] pay, input bit garbage);
        tx_t t;
        int unsigned off;
        t.logb = logb;
        t.loge = loge;
        t.pkt  = '0;
        t.pkt[LOGB-1:0]      = logb;
        t.pkt[LOGB +: LOGE]  = loge;
        off = LOGB + LOGE;
        for (int i = 0; i < int'(LOGB); i++) begin
            for (int b = 0; b < int'(CW); b++) t.pay[i][b] = (b < int'(ch_w[i])) ? pay[i][b] : 1'b0;
            if (logb[i]) begin
                for (int b = 0; b < int'(ch_w[i]); b++) t.pkt[off + b] = t.pay[i][b];
                off += ch_w[i];
            end
        end
        t.len   = off;
        t.width = off;
        if (garbage) begin
            for (int b = int'(off); b < int'(WIDTH); b++) t.pkt[b] = 1'($urandom_range(0, 1));
        end
        return t;
    endfunction

    function automatic void add_beats(input tx_t t);
        beat_t b;
        b.loge = t.loge;
        if (t.logb == '0) begin
            b.idx = 0; b.data = '0; b.empty = 1'b1; b.last = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int i = 0; i < int'(LOGB); i++) begin
                if (t.logb[i]) begin
                    b.idx   = i;
                    b.data  = t.pay[i];
                    b.empty = 1'b0;
                    b.last  = ((t.logb >> (i + 1)) == 0);
                    exp_q.push_back(b);
                end
            end
        end
    endfunction

    // One clock: drive at the falling edge, compare 1ns later, advance model by handshakes.
    task automatic cycle();
        bit    have;
        bit    exp_rdy;
        beat_t b;
        have = (tx_q.size() > 0) && (!rand_mode || ($urandom_range(0, 3) != 0));
        bus.in_valid = have;
        bus.in_pkt   = have ? tx_q[0].pkt : '0;
        bus.in_width = have ? OW'(tx_q[0].width) : '0;
        if (stall_cnt > 0 && exp_q.size() > 0) begin
            bus.out_ready = 1'b0;
            stall_cnt--;
        end else begin
            bus.out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        #1;
        check("pkt_cnt", pkt_cnt, model_cnt);
        check("len_err", len_err, model_err);
        check("out_valid", bus.out_valid, exp_q.size() > 0);
        exp_rdy = (exp_q.size() == 0) || (exp_q[0].last && bus.out_ready);
        check("in_ready", bus.in_ready, exp_rdy);
        if (exp_q.size() > 0) begin
            b = exp_q[0];
            check("out_idx", bus.out_idx, b.idx);
            check("out_data", bus.out_data, b.data);
            check("out_empty", bus.out_empty, b.empty);
            check("out_last", bus.out_last, b.last);
            check("out_loge", bus.out_loge, b.loge);
            if (bus.out_ready) begin
                if (b.last) model_cnt++;
                void'(exp_q.pop_front());
            end
        end
        if (have && exp_rdy) begin
            add_beats(tx_q[0]);
            if (tx_q[0].width < tx_q[0].len) model_err = 1'b1;
            void'(tx_q.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int max_cycles);
        int n = 0;
        while ((tx_q.size() > 0 || exp_q.size() > 0) && n < max_cycles) begin
            cycle();
            n++;
        end
        last_cycles = n;
        check("drain", (tx_q.size() == 0) && (exp_q.size() == 0), 1'b1);
    endtask

    task automatic rand_batch(input int count, input bit allow_short);
        tx_t                     t;
        logic [LOGB-1:0][CW-1:0] p;
        for (int k = 0; k < count; k++) begin
            for (int i = 0; i < int'(LOGB); i++) p[i] = CW'($urandom);
            t = make_pkt(LOGB'($urandom), LOGE'($urandom), p, 1'b1);
            if (allow_short && $urandom_range(0, 3) == 0) t.width = $urandom_range(0, t.len - 1);
            else t.width = t.len + $urandom_range(0, WIDTH - t.len);
            tx_q.push_back(t);
        end
    endtask

    initial begin
        tx_t                     t;
        logic [LOGB-1:0][CW-1:0] p;
        int                      n;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_pkt    = '0;
        bus.in_width  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_empty", bus.out_empty, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_loge", bus.out_loge, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_len_err", len_err, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Two of three channels, stored at [12:5] and [16:13].
        p = '0; p[0] = 16'hA5; p[2] = 16'h3;
        t = make_pkt(3'b101, 2'b10, p, 1'b0);
        check("t1_pkt_bits", t.pkt[16:5], 12'h3A5);
        tx_q.push_back(t);
        run(20);
        check("t1_cycles", last_cycles, 3);
        check("t1_pkt_cnt", pkt_cnt, 1);

        // Empty bitmap.
        tx_q.push_back(make_pkt(3'b000, 2'b01, '0, 1'b0));
        run(20);
        check("t2_pkt_cnt", pkt_cnt, 2);

        // Back-to-back full packets.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < int'(LOGB); i++) p[i] = CW'($urandom);
            tx_q.push_back(make_pkt(3'b111, LOGE'($urandom), p, 1'b0));
        end
        run(20);
        check("t3_cycles", last_cycles, 7);
        check("t3_pkt_cnt", pkt_cnt, 4);

        // Backpressure on the first beat.
        p = '0; p[0] = 16'hA5; p[2] = 16'h3;
        tx_q.push_back(make_pkt(3'b101, 2'b10, p, 1'b0));
        stall_cnt = 4;
        run(20);
        check("t4_cycles", last_cycles, 7);
        check("t4_pkt_cnt", pkt_cnt, 5);

        rand_mode = 1'b1;
        rand_batch(25, 1'b0);
        run(2000);
        check("rand_no_len_err", len_err, 0);
        rand_mode = 1'b0;

        // Short declared length.
        p = '0; p[1] = 16'hBEEF;
        t = make_pkt(3'b010, 2'b11, p, 1'b0);
        t.width = 10;
        tx_q.push_back(t);
        run(20);
        check("t5_len_err", len_err, 1);
        tx_q.push_back(make_pkt(3'b001, 2'b00, p, 1'b0));
        run(20);
        check("t5_len_err_sticky", len_err, 1);

        // Reset after the first beat of a three-beat packet.
        for (int i = 0; i < int'(LOGB); i++) p[i] = CW'($urandom);
        tx_q.push_back(make_pkt(3'b111, 2'b01, p, 1'b0));
        n = 0;
        while (exp_q.size() != 2 && n < 10) begin
            cycle();
            n++;
        end
        check("t6_mid_packet", exp_q.size(), 2);
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("t6_out_valid", bus.out_valid, 0);
        check("t6_pkt_cnt", pkt_cnt, 0);
        check("t6_in_ready", bus.in_ready, 1);
        check("t6_len_err", len_err, 0);
        exp_q.delete();
        tx_q.delete();
        model_cnt = 0;
        model_err = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        repeat (3) cycle();

        rand_mode = 1'b1;
        rand_batch(25, 1'b1);
        run(2000);
        rand_mode = 1'b0;
        check("final_pkt_cnt", pkt_cnt, 25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
